approx_mul_inverse_div: RTL and testbench

- Sequential unsigned restoring divider. It is the inverse path for the 8x8 unsigned multiplier family: it recovers a quotient and remainder from a 16-bit product-width dividend and an 8-bit divisor.
- Used by the error-characterisation datapath to divide products by operands and accumulate relative error.
- Radix-2, one quotient bit per cycle.
- Valid/ready handshake on both input and output sides.

---
 rtl/approx_div_pkg.sv | 18 +
 rtl/approx_mul_inverse_div_step.sv | 21 ++
 rtl/approx_mul_inverse_div.sv | 111 +++++++++++
 tb/tb_approx_mul_inverse_div.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/approx_div_pkg.sv
// Shared types and defaults for the product-width restoring divider.
// Imported by the divider FSM and its step sub-module.
package approx_div_pkg;

  localparam int DW_DEF = 16;
  localparam int VW_DEF = 8;
  localparam int CW_DEF = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Every quotient bit takes this value on divide-by-zero.
  localparam logic DBZ_FILL = 1'b1;

endpackage

// File: rtl/approx_mul_inverse_div_step.sv
// One radix-2 restoring iteration: shift in a dividend bit,
// subtract the divisor if it fits.
module div_restoring_step #(
  parameter int VW = 8
) (
  input  logic [VW:0]   partial_rem,
  input  logic          next_bit,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   new_rem,
  output logic          q_bit
);

  assign q_bit = {partial_rem, next_bit} >= {2'b00, divisor};

  // The running remainder is always below the divisor, so the
  // top bit dropped by the casts is zero.
  assign new_rem = q_bit
    ? (VW+1)'({partial_rem, next_bit} - {2'b00, divisor})
    : (VW+1)'({partial_rem, next_bit});

endmodule

// File: rtl/approx_mul_inverse_div.sv
// Sequential unsigned restoring divider, one quotient bit per
// cycle, valid/ready on both sides.
module approx_mul_inverse_div
  import approx_div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [DW-1:0] sreg;
  logic [VW-1:0] dvs;
  logic [VW:0]   prem;
  logic [VW:0]   prem_nx;
  logic          q_bit;
  logic          accept;
  logic          fire;
  logic          last;

  assign accept = in_valid && in_ready;
  assign fire   = out_valid && out_ready;
  assign last   = (state == CALC) && (cnt == '0);

  div_restoring_step #(
    .VW(VW)
  ) u_step (
    .partial_rem(prem),
    .next_bit   (sreg[DW-1]),
    .divisor    (dvs),
    .new_rem    (prem_nx),
    .q_bit      (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept)
        state_nx = (divisor == '0) ? DONE : CALC;
      CALC: if (cnt == '0) state_nx = DONE;
      DONE: if (fire) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (1'b1)
      (state == IDLE): in_ready  = 1'b1;
      (state == DONE): out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      sreg        <= '0;
      dvs         <= '0;
      prem        <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      sreg        <= dividend;
      dvs         <= divisor;
      prem        <= '0;
      cnt         <= CW'(DW-1);
      div_by_zero <= (divisor == '0);
      if (divisor == '0) begin
        quotient  <= {DW{DBZ_FILL}};
        remainder <= dividend[VW-1:0];
      end
    end else if (state == CALC) begin
      sreg <= {sreg[DW-2:0], q_bit};
      prem <= prem_nx;
      if (last) begin
        quotient  <= {sreg[DW-2:0], q_bit};
        remainder <= prem_nx[VW-1:0];
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  a_excl: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(out_valid && in_ready)
  );

endmodule

// File: tb/tb_approx_mul_inverse_div.sv
// Directed vectors for the restoring divider, plus reset and
// backpressure sequences.
module tb_approx_mul_inverse_div;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  approx_mul_inverse_div dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    int          hold;
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  name, act, exp);
  endtask

  task automatic start_op(input logic [15:0] a,
                          input logic [7:0] b);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 50) chk("accept_wait", 32'(in_ready), 1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int spur;

    vecs[0] = '{16'd1000,  8'd7,   0, 16'd142,   8'd6,   1'b0, 16};
    vecs[1] = '{16'd65535, 8'd255, 0, 16'd257,   8'd0,   1'b0, 16};
    vecs[2] = '{16'd40000, 8'd200, 5, 16'd200,   8'd0,   1'b0, 16};
    vecs[3] = '{16'd5,     8'd9,   0, 16'd0,     8'd5,   1'b0, 16};
    vecs[4] = '{16'd255,   8'd1,   0, 16'd255,   8'd0,   1'b0, 16};
    vecs[5] = '{16'd12345, 8'd100, 0, 16'd123,   8'd45,  1'b0, 16};
    vecs[6] = '{16'd65535, 8'd1,   0, 16'd65535, 8'd0,   1'b0, 16};
    vecs[7] = '{16'd1234,  8'd0,   5, 16'd65535, 8'hD2,  1'b1, 0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(in_ready),    1);
    chk("rst_out_valid", 32'(out_valid),   0);
    chk("rst_quotient",  32'(quotient),    0);
    chk("rst_remainder", 32'(remainder),   0);
    chk("rst_dbz",       32'(div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_done(lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_quotient", i), 32'(quotient), 32'(vecs[i].q));
      chk($sformatf("v%0d_remainder", i), 32'(remainder), 32'(vecs[i].r));
      chk($sformatf("v%0d_dbz", i), 32'(div_by_zero), 32'(vecs[i].z));
      chk($sformatf("v%0d_busy", i), 32'(in_ready), 0);
      for (int k = 0; k < vecs[i].hold; k++) begin
        @(posedge clk); #1;
        chk($sformatf("v%0d_bp_valid", i), 32'(out_valid), 1);
        chk($sformatf("v%0d_bp_ready", i), 32'(in_ready), 0);
        chk($sformatf("v%0d_bp_q", i), 32'(quotient), 32'(vecs[i].q));
        chk($sformatf("v%0d_bp_r", i), 32'(remainder), 32'(vecs[i].r));
      end
      finish_op();
      chk($sformatf("v%0d_idle_ready", i), 32'(in_ready), 1);
      chk($sformatf("v%0d_idle_valid", i), 32'(out_valid), 0);
    end

    // previous result was the divide-by-zero vector
    start_op(16'd1000, 8'd7);
    chk("dbz_cleared", 32'(div_by_zero), 0);
    chk("hold_quotient", 32'(quotient), 32'hFFFF);
    chk("hold_remainder", 32'(remainder), 32'hD2);
    repeat (8) @(posedge clk);
    #1;
    chk("calc_busy", 32'(in_ready), 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid),   0);
    chk("mid_rst_ready", 32'(in_ready),    1);
    chk("mid_rst_q",     32'(quotient),    0);
    chk("mid_rst_r",     32'(remainder),   0);
    chk("mid_rst_dbz",   32'(div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;
    spur = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) spur++;
    end
    chk("no_spurious_valid", 32'(spur), 0);

    start_op(16'd300, 8'd3);
    wait_done(lat);
    chk("post_rst_latency",   32'(lat),         16);
    chk("post_rst_quotient",  32'(quotient),    100);
    chk("post_rst_remainder", 32'(remainder),   0);
    chk("post_rst_dbz",       32'(div_by_zero), 0);
    finish_op();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
